// File: rtl/eth_tlptap_pkt.sv
// eth_tlptap_pkt: packet-aware passive AXI-Stream tap feeding an almost-full FIFO,
// with drop/truncate handling, error end markers, tuser filter and saturating stats.
module eth_tlptap_pkt #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = C_DATA_WIDTH / 32,
    parameter int USER_WIDTH = 8,
    parameter int DIN_WIDTH = 2 + 4 * KEEP_WIDTH + C_DATA_WIDTH + USER_WIDTH,
    parameter bit FILTER_EN = 1'b0,
    parameter logic [USER_WIDTH-1:0] FILTER_MASK = 8'hFF,
    parameter logic [USER_WIDTH-1:0] FILTER_VALUE = 8'h00,
    parameter int CNT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    input  logic                    s_axis_tlast,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tready,
    input  logic                    enable,
    input  logic                    clear_stats,
    output logic                    wr_en,
    output logic [DIN_WIDTH-1:0]    din,
    input  logic                    full,
    output logic [CNT_WIDTH-1:0]    pkt_cnt,
    output logic [CNT_WIDTH-1:0]    drop_cnt,
    output logic [CNT_WIDTH-1:0]    trunc_cnt
);

    typedef enum logic [1:0] {IDLE, PASS, DROP, TRUNC} state_t;

    state_t                    state;
    logic                      fix_pending;
    logic                      beat;
    logic                      sop_ok;
    logic                      wr_beat;
    logic                      pkt_inc;
    logic                      drop_inc;
    logic                      trunc_inc;
    logic [4*KEEP_WIDTH-1:0]   byte_keep;

    always_comb begin
        for (int i = 0; i < KEEP_WIDTH; i++) byte_keep[4*i +: 4] = {4{s_axis_tkeep[i]}};
        beat      = s_axis_tvalid && s_axis_tready;
        sop_ok    = enable && (!FILTER_EN || ((s_axis_tuser & FILTER_MASK) == FILTER_VALUE));
        // fix_pending is never set while in PASS, so beat writes and markers never collide
        wr_beat   = beat && !full && (state == PASS || (state == IDLE && sop_ok && !fix_pending));
        pkt_inc   = wr_beat && s_axis_tlast;
        drop_inc  = beat && state == IDLE && sop_ok && (full || fix_pending);
        trunc_inc = beat && state == PASS && full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fix_pending <= 1'b0;
            wr_en       <= 1'b0;
            din         <= '0;
            pkt_cnt     <= '0;
            drop_cnt    <= '0;
            trunc_cnt   <= '0;
        end else begin
            wr_en <= wr_beat;
            din   <= wr_beat ? {1'b0, byte_keep, s_axis_tdata, s_axis_tuser, s_axis_tlast} : '0;
            if (beat) begin
                case (state)
                    IDLE:  state <= s_axis_tlast ? IDLE : (wr_beat ? PASS : DROP);
                    PASS:  state <= s_axis_tlast ? IDLE : (full ? TRUNC : PASS);
                    TRUNC: state <= s_axis_tlast ? IDLE : TRUNC;
                    DROP:  state <= s_axis_tlast ? IDLE : DROP;
                endcase
                if (s_axis_tlast && (state == TRUNC || trunc_inc)) fix_pending <= 1'b1;
            end
            if (fix_pending && !full) begin
                wr_en       <= 1'b1;
                din         <= {1'b1, {(DIN_WIDTH-2){1'b0}}, 1'b1};
                fix_pending <= 1'b0;
            end
            pkt_cnt   <= clear_stats ? '0 : (pkt_inc && !(&pkt_cnt)) ? pkt_cnt + CNT_WIDTH'(1) : pkt_cnt;
            drop_cnt  <= clear_stats ? '0 : (drop_inc && !(&drop_cnt)) ? drop_cnt + CNT_WIDTH'(1) : drop_cnt;
            trunc_cnt <= clear_stats ? '0 : (trunc_inc && !(&trunc_cnt)) ? trunc_cnt + CNT_WIDTH'(1) : trunc_cnt;
        end
    end

endmodule

// File: tb/tb_eth_tlptap_pkt.sv
// tb_eth_tlptap_pkt: directed scoreboard bench for eth_tlptap_pkt with the tuser
// filter on and 4-bit counters so saturation is reachable.
module tb_eth_tlptap_pkt;

    localparam int DW = 82;
    localparam logic [DW-1:0] MARK = {1'b1, 80'b0, 1'b1};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   s_axis_tdata = '0;
    logic [7:0]    s_axis_tuser = '0;
    logic          s_axis_tlast = 1'b0;
    logic [1:0]    s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready = 1'b0;
    logic          enable = 1'b1;
    logic          clear_stats = 1'b0;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          full = 1'b0;
    logic [3:0]    pkt_cnt;
    logic [3:0]    drop_cnt;
    logic [3:0]    trunc_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q[$];

    eth_tlptap_pkt #(
        .FILTER_EN(1'b1),
        .FILTER_MASK(8'h0F),
        .FILTER_VALUE(8'h03),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .enable(enable),
        .clear_stats(clear_stats),
        .wr_en(wr_en),
        .din(din),
        .full(full),
        .pkt_cnt(pkt_cnt),
        .drop_cnt(drop_cnt),
        .trunc_cnt(trunc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cnts(input string tag, input logic [3:0] p, input logic [3:0] d, input logic [3:0] t);
        chk({tag, "_pkt"}, DW'(pkt_cnt), DW'(p));
        chk({tag, "_drop"}, DW'(drop_cnt), DW'(d));
        chk({tag, "_trunc"}, DW'(trunc_cnt), DW'(t));
    endtask

    // One clock of stimulus; w queues the FIFO word this beat must produce.
    task automatic cyc(input logic v, input logic [63:0] d, input logic [1:0] k,
                       input logic [7:0] u, input logic l, input logic f, input logic w);
        s_axis_tvalid = v;
        s_axis_tready = v;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        full          = f;
        if (w) exp_q.push_back({1'b0, {4{k[1]}}, {4{k[0]}}, d, u, l});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic f);
        cyc(1'b0, 64'h0, 2'b00, 8'h00, 1'b0, f, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                logic [DW-1:0] e;
                e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                chk("fifo_word", din, e);
            end else begin
                chk("idle_din", din, '0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", DW'(wr_en), '0);
        chk("rst_din", din, '0);
        cnts("rst", 4'd0, 4'd0, 4'd0);
        rst_n = 1'b1;
        idle(1'b0);

        cyc(1'b1, 64'h1111_0000_0000_0001, 2'b11, 8'hA3, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 64'h1111_0000_0000_0002, 2'b11, 8'hA3, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 64'h1111_0000_0000_0003, 2'b01, 8'hA3, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        cnts("three_beat", 4'd1, 4'd0, 4'd0);

        cyc(1'b1, 64'h2222_0000_0000_0000, 2'b11, 8'hA3, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 64'h2222_0000_0000_0001, 2'b11, 8'hA3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h2222_0000_0000_0002, 2'b11, 8'hA3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h2222_0000_0000_0003, 2'b11, 8'hA3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 64'h2233_0000_0000_0000, 2'b11, 8'hA3, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 64'h2233_0000_0000_0001, 2'b10, 8'hA3, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        cnts("drop_full", 4'd2, 4'd1, 4'd0);

        cyc(1'b1, 64'h3333_0000_0000_0000, 2'b11, 8'hB3, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 64'h3333_0000_0000_0001, 2'b11, 8'hB3, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 64'h3333_0000_0000_0002, 2'b11, 8'hB3, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 64'h3333_0000_0000_0003, 2'b11, 8'hB3, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 64'h3333_0000_0000_0004, 2'b11, 8'hB3, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        exp_q.push_back(MARK);
        idle(1'b0);
        idle(1'b0);
        cnts("trunc", 4'd2, 4'd1, 4'd1);

        cyc(1'b1, 64'h4444_0000_0000_0000, 2'b11, 8'hA3, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 64'h4444_0000_0000_0001, 2'b11, 8'hA3, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        cyc(1'b1, 64'h4455_0000_0000_0000, 2'b11, 8'hA3, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(MARK);
        cyc(1'b1, 64'h4455_0000_0000_0001, 2'b11, 8'hA3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 64'h4466_0000_0000_0000, 2'b01, 8'hA3, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        cnts("pending_drop", 4'd3, 4'd2, 4'd2);

        cyc(1'b1, 64'h5555_0000_0000_0000, 2'b11, 8'h04, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h5555_0000_0000_0001, 2'b11, 8'h04, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        cyc(1'b1, 64'h5566_0000_0000_0000, 2'b11, 8'hA3, 1'b1, 1'b0, 1'b0);
        enable = 1'b1;
        idle(1'b0);
        cnts("filtered", 4'd3, 4'd2, 4'd2);
        cyc(1'b1, 64'h5577_0000_0000_0000, 2'b11, 8'hA3, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 64'h5588_0000_0000_0000, 2'b11, 8'h13, 1'b0, 1'b0, 1'b1);
        enable = 1'b0;
        cyc(1'b1, 64'h5588_0000_0000_0001, 2'b11, 8'h04, 1'b1, 1'b0, 1'b1);
        enable = 1'b1;
        idle(1'b0);
        idle(1'b0);
        cnts("accepted", 4'd5, 4'd2, 4'd2);

        for (int i = 0; i < 13; i++)
            cyc(1'b1, 64'h6600_0000_0000_0000 + 64'(i), 2'b11, 8'hA3, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        cnts("saturate", 4'hF, 4'd2, 4'd2);

        clear_stats = 1'b1;
        cyc(1'b1, 64'h7777_0000_0000_0000, 2'b11, 8'hA3, 1'b1, 1'b0, 1'b1);
        clear_stats = 1'b0;
        idle(1'b0);
        cnts("clear", 4'd0, 4'd0, 4'd0);
        cyc(1'b1, 64'h7788_0000_0000_0000, 2'b11, 8'hA3, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        cnts("after_clear", 4'd1, 4'd0, 4'd0);

        cyc(1'b1, 64'h8888_0000_0000_0000, 2'b11, 8'hA3, 1'b0, 1'b0, 1'b1);
        s_axis_tdata = 64'h8888_0000_0000_0001;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", DW'(wr_en), '0);
        chk("async_rst_din", din, '0);
        cnts("async_rst", 4'd0, 4'd0, 4'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 64'h8888_0000_0000_0002, 2'b01, 8'hA3, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        cnts("post_rst_sop", 4'd1, 4'd0, 4'd0);
        chk("queue_empty", DW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eth_tlptap_pkt.md
Name: eth_tlptap_pkt

Overview:
Parametrised, packet-aware successor of the combinational TLP tap. Snoops an AXI-Stream Eth+IP+UDP+TLP stream without backpressuring it and writes accepted beats into a downstream FIFO, one registered cycle later. Adds packet-granular drop on FIFO full, truncation with an error-tagged end marker, a tuser filter, enable gating and saturating statistics counters.

Parameters:
C_DATA_WIDTH, 64, stream data width in bits (multiple of 32).
KEEP_WIDTH, C_DATA_WIDTH/32, dword keep bits.
USER_WIDTH, 8, tuser width.
DIN_WIDTH, 2+4*KEEP_WIDTH+C_DATA_WIDTH+USER_WIDTH, FIFO word width.
FILTER_EN, 0, 1 = apply tuser filter at SOP.
FILTER_MASK, 8'hFF, tuser bits compared.
FILTER_VALUE, 8'h00, required value of masked tuser bits.
CNT_WIDTH, 32, statistics counter width.

Ports:
clk  in  1  core clock
rst_n  in  1  reset; one clock domain, asynchronous assert, active-low
s_axis_tdata  in  C_DATA_WIDTH  tapped data
s_axis_tuser  in  USER_WIDTH  tapped user
s_axis_tlast  in  1  tapped last
s_axis_tkeep  in  KEEP_WIDTH  tapped dword keep
s_axis_tvalid  in  1  tapped valid
s_axis_tready  in  1  tapped ready (observed only)
enable  in  1  capture enable, sampled at SOP
clear_stats  in  1  synchronous counter clear
wr_en  out  1  FIFO write strobe (registered)
din  out  DIN_WIDTH  {err, byte_keep, data, user, last} (registered)
full  in  1  FIFO almost-full: asserted while <=1 free entry
pkt_cnt  out  CNT_WIDTH  complete packets written
drop_cnt  out  CNT_WIDTH  whole packets dropped (full or pending marker)
trunc_cnt  out  CNT_WIDTH  packets truncated mid-stream

Behaviour:
- Beat = s_axis_tvalid && s_axis_tready. Block never drives the stream.
- byte_keep: each keep bit replicated 4x, bit i -> bytes 4i..4i+3.
- Latency: beat written on cycle N appears as wr_en/din on N+1; wr_en=0 cycles drive din=0.
- full sampled in the beat cycle; FIFO must give almost-full semantics.
- States: IDLE (next beat is SOP), PASS, DROP, TRUNC. Flag fix_pending.
- IDLE, beat: reject if !enable or (FILTER_EN && (tuser&MASK)!=VALUE) -> no count, DROP unless tlast. Else if full or fix_pending -> drop_cnt++, DROP unless tlast. Else write; tlast -> pkt_cnt++, stay IDLE; else PASS.
- PASS, beat: !full -> write; tlast -> pkt_cnt++, IDLE. full -> trunc_cnt++, no write; tlast -> fix_pending=1, IDLE; else TRUNC.
- TRUNC: discard beats; tlast beat -> fix_pending=1, IDLE.
- DROP: discard beats; tlast -> IDLE.
- Marker: fix_pending && !full -> write {err=1, keep=0, data=0, user=0, last=1}, clear fix_pending. SOP arriving the same cycle is dropped (drop_cnt++); marker always precedes any later packet.
- Counters saturate at all-ones; clear_stats zeroes all three and beats any same-cycle increment.
- Reset: state IDLE, fix_pending=0, wr_en=0, din=0, all counters 0. Reset mid-packet: remainder of that packet seen as SOP-less beats; first beat after reset is treated as SOP.
- enable/filter changes mid-packet have no effect until next SOP.

Test Plan:
- 3-beat packet, keep=2'b11 then 2'b01 last, full=0, enable=1 -> 3 writes, last din byte_keep=8'h0F, last=1, err=0, pkt_cnt=1.
- full=1 on SOP of 4-beat packet, deasserted next cycle -> no writes for that packet, drop_cnt=1, next packet written intact.
- full asserted on beat 2 of 5 -> beats 0-1 written, 2-4 discarded, trunc_cnt=1; once full=0, single marker with err=1,last=1, din data=0.
- Marker pending while full held, new 2-beat SOP arrives -> packet dropped, drop_cnt++, marker written first cycle full=0, following packet written normally.
- FILTER_EN=1, MASK=8'h0F, VALUE=8'h03: tuser=8'hA3 packet written; tuser=8'h04 packet ignored, no counters change.
- pkt_cnt preset near saturation (CNT_WIDTH=4, 16 packets) -> holds 4'hF; clear_stats coincident with packet end -> 0; async rst_n low mid-PASS -> wr_en=0 immediately, counters 0.
